// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline stage sequencer.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } pipe_state_t;

  localparam int DEF_NSTAGES = 5;
  localparam int DEF_CNTW    = 32;

endpackage

// File: rtl/pipe_prefix_or.sv
// Suffix-OR chain: any[i] is set when any request at stage i or an older stage is set.
module pipe_prefix_or #(
  parameter int NSTAGES = 5
) (
  input  logic [NSTAGES-1:0] req,
  output logic [NSTAGES-1:0] any
);

  for (genvar i = 0; i < NSTAGES; i++) begin : g_or
    assign any[i] = |req[NSTAGES-1:i];
  end

endmodule

// File: rtl/pipe_stage_ctrl.sv
// Pipeline stage sequencer: en/clr strobes, per-stage valid tracking, drain/halt handshake.
// Define PIPE_CTRL_PERF_CNT_EN to build the stall/flush performance counters.
module pipe_stage_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NSTAGES = DEF_NSTAGES,
  parameter int CNTW    = DEF_CNTW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NSTAGES-1:0] stall_req,
  input  logic [NSTAGES-1:0] flush_req,
  input  logic               drain_req,
  input  logic               resume,
  output logic [NSTAGES-1:0] en,
  output logic [NSTAGES-1:0] clr,
  output logic [NSTAGES-1:0] valid,
  output logic               out_valid,
  output logic               halted,
  output logic [CNTW-1:0]    stall_cycles,
  output logic [CNTW-1:0]    flush_count
);

  pipe_state_t        state;
  logic [NSTAGES-1:0] stall;
  logic [NSTAGES-1:0] flush;
  logic [NSTAGES-1:0] feed;
  logic [NSTAGES-1:0] valid_nxt;

  pipe_prefix_or #(.NSTAGES(NSTAGES)) u_stall_or (.req(stall_req), .any(stall));
  pipe_prefix_or #(.NSTAGES(NSTAGES)) u_flush_or (.req(flush_req), .any(flush));

  // A stalled stage feeding a moving one gets a bubble via the second clr term.
  always_comb begin
    en        = '0;
    clr       = '1;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    if (!reset) begin
      for (int i = 0; i < NSTAGES; i++) begin
        en[i] = (~stall[i] | flush[i]) & (state != HALTED);
      end
      clr[0] = flush[0];
      for (int i = 1; i < NSTAGES; i++) begin
        clr[i] = flush[i] | (stall[i-1] & ~stall[i]);
      end
      in_ready  = (state == RUN) & ~stall[0];
      out_valid = valid[NSTAGES-1] & ~stall[NSTAGES-1] & ~flush[NSTAGES-1];
    end
  end

  assign feed      = {valid[NSTAGES-2:0], in_valid & in_ready};
  assign valid_nxt = ((valid & ~en) | (feed & en)) & ~clr;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= '0;
    end else begin
      valid <= valid_nxt;
    end
  end

  // DRAIN waits for an empty pipe before halting; drain_req dropping does not abort it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
    end else begin
      case (state)
        RUN:     if (drain_req)     state <= DRAIN;
        DRAIN:   if (valid == '0)   state <= HALTED;
        HALTED:  if (resume)        state <= RUN;
        default:                    state <= RUN;
      endcase
    end
  end

  assign halted = (state == HALTED);

`ifdef PIPE_CTRL_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall[0]) stall_cycles <= stall_cycles + CNTW'(1);
      if (flush[0]) flush_count  <= flush_count + CNTW'(1);
    end
  end
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Randomized self-checking bench for pipe_stage_ctrl against an item-tracking reference model.
module tb_pipe_stage_ctrl;

  localparam int N = 5;
  localparam int W = 32;
`ifdef PIPE_CTRL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset, in_valid, drain_req, resume;
  logic [N-1:0] stall_req, flush_req;
  logic         in_ready, out_valid, halted;
  logic [N-1:0] en, clr, valid;
  logic [W-1:0] stall_cycles, flush_count;

  int checks   = 0;
  int failures = 0;

  // Reference model: item tag per stage (0 = empty), mode 0 run / 1 drain / 2 halted.
  int           ids [N];
  int           nextId = 1;
  int           mode   = 0;
  logic [W-1:0] mStall = '0;
  logic [W-1:0] mFlush = '0;

  pipe_stage_ctrl #(.NSTAGES(N), .CNTW(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .stall_req(stall_req), .flush_req(flush_req), .drain_req(drain_req),
    .resume(resume), .en(en), .clr(clr), .valid(valid), .out_valid(out_valid),
    .halted(halted), .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s at %0t: observed=%h expected=%h", tag, $time, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic inv, input logic [N-1:0] sreq,
                               input logic [N-1:0] freq, input logic drn, input logic res);
    logic [N-1:0] st, fl, expEn, expClr, expValid;
    logic         expReady, expOut, empty, take;
    int           nids [N];
    @(negedge clk);
    reset = rst; in_valid = inv; stall_req = sreq; flush_req = freq;
    drain_req = drn; resume = res;
    #1;
    for (int i = 0; i < N; i++) begin
      st[i] = 1'b0;
      fl[i] = 1'b0;
      for (int j = i; j < N; j++) begin
        st[i] = st[i] | sreq[j];
        fl[i] = fl[i] | freq[j];
      end
    end
    empty = 1'b1;
    for (int i = 0; i < N; i++) begin
      expValid[i] = (ids[i] != 0);
      if (ids[i] != 0) empty = 1'b0;
    end
    if (rst) begin
      expEn = '0; expClr = '1; expReady = 1'b0; expOut = 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        expEn[i]  = (mode != 2) && (!st[i] || fl[i]);
        expClr[i] = fl[i] || (i > 0 && st[i-1] && !st[i]);
      end
      expReady = (mode == 0) && !st[0];
      expOut   = (ids[N-1] != 0) && !st[N-1] && !fl[N-1];
    end
    checkOutput("en",        64'(en),        64'(expEn));
    checkOutput("clr",       64'(clr),       64'(expClr));
    checkOutput("in_ready",  64'(in_ready),  64'(expReady));
    checkOutput("out_valid", 64'(out_valid), 64'(expOut));
    checkOutput("valid",     64'(valid),     64'(expValid));
    checkOutput("halted",    64'(halted),    64'(mode == 2));
    checkOutput("stall_cycles", 64'(stall_cycles), PERF ? 64'(mStall) : 64'd0);
    checkOutput("flush_count",  64'(flush_count),  PERF ? 64'(mFlush) : 64'd0);
    // Advance the model by one clock.
    if (rst) begin
      for (int i = 0; i < N; i++) ids[i] = 0;
      mode = 0; mStall = '0; mFlush = '0;
    end else begin
      take = inv && expReady;
      for (int i = 0; i < N; i++) begin
        if (expClr[i])     nids[i] = 0;
        else if (expEn[i]) nids[i] = (i == 0) ? (take ? nextId : 0) : ids[i-1];
        else               nids[i] = ids[i];
      end
      if (take) nextId++;
      for (int i = 0; i < N; i++) ids[i] = nids[i];
      if (|sreq) mStall = mStall + 1;
      if (|freq) mFlush = mFlush + 1;
      if (mode == 0 && drn)        mode = 1;
      else if (mode == 1 && empty) mode = 2;
      else if (mode == 2 && res)   mode = 0;
    end
  endtask

  initial begin
    int guard;
    reset = 1'b1; in_valid = 1'b0; stall_req = '0; flush_req = '0;
    drain_req = 1'b0; resume = 1'b0;
    for (int i = 0; i < N; i++) ids[i] = 0;

    repeat (2) applyStimulus(1, 0, '0, '0, 0, 0);
    // Three items walk the empty pipe.
    repeat (3) applyStimulus(0, 1, '0, '0, 0, 0);
    repeat (7) applyStimulus(0, 0, '0, '0, 0, 0);
    // Full pipe, middle stall then resume.
    repeat (5) applyStimulus(0, 1, '0, '0, 0, 0);
    repeat (2) applyStimulus(0, 1, 5'b00100, '0, 0, 0);
    repeat (4) applyStimulus(0, 1, '0, '0, 0, 0);
    // Flush beats a younger stall.
    applyStimulus(0, 1, 5'b00010, 5'b01000, 0, 0);
    repeat (3) applyStimulus(0, 0, '0, '0, 0, 0);
    // Drain with three items in flight, then resume.
    repeat (3) applyStimulus(0, 1, '0, '0, 0, 0);
    applyStimulus(0, 1, '0, '0, 1, 0);
    guard = 0;
    while (mode != 2 && guard < 30) begin
      applyStimulus(0, 1, '0, '0, 0, 0);
      guard++;
    end
    repeat (2) applyStimulus(0, 1, '0, '0, 1, 0);
    applyStimulus(0, 1, '0, '0, 0, 1);
    repeat (2) applyStimulus(0, 1, '0, '0, 0, 0);
    // Reset in the middle of a drain.
    applyStimulus(0, 1, '0, '0, 1, 0);
    applyStimulus(0, 1, '0, '0, 0, 0);
    applyStimulus(1, 1, '0, '0, 0, 0);
    repeat (2) applyStimulus(0, 1, '0, '0, 0, 0);
    // Exact counter totals: 7 stall cycles and 2 flush cycles after reset.
    applyStimulus(1, 0, '0, '0, 0, 0);
    repeat (7) applyStimulus(0, 1, 5'(1 << $urandom_range(N-1)), '0, 0, 0);
    repeat (2) applyStimulus(0, 1, '0, 5'(1 << $urandom_range(N-1)), 0, 0);
    applyStimulus(0, 0, '0, '0, 0, 0);
    if (PERF) begin
      checkOutput("stall_total", 64'(stall_cycles), 64'd7);
      checkOutput("flush_total", 64'(flush_count),  64'd2);
    end

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      applyStimulus(($urandom_range(199) == 0),
                    ($urandom_range(1) == 1),
                    ($urandom_range(3) == 0) ? 5'($urandom) : '0,
                    ($urandom_range(9) == 0) ? 5'($urandom) : '0,
                    ($urandom_range(39) == 0),
                    ($urandom_range(7) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
